// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for the shared shift ALU.
// Accepts one operation at a time, runs it through the ALU from registered
// operands, captures the result and hands it back to the requester that won.
module alu_arbiter #(
  parameter int w = 3
) (
  input  logic         clk,
  input  logic         rst,
  // requester 0
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [w-1:0] req0_opcode,
  input  logic [w-1:0] req0_a,
  input  logic [w-1:0] req0_b,
  // requester 1
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [w-1:0] req1_opcode,
  input  logic [w-1:0] req1_a,
  input  logic [w-1:0] req1_b,
  // responses
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [w-1:0] rsp0_y,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [w-1:0] rsp1_y,
  // shared ALU
  output logic [w-1:0] alu_opcode,
  output logic [w-1:0] alu_a,
  output logic [w-1:0] alu_b,
  input  logic [w-1:0] alu_y,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_next;

  logic [w-1:0] r_op;
  logic [w-1:0] r_a;
  logic [w-1:0] r_b;
  logic [w-1:0] r_res;
  logic         r_owner;
  logic         r_prio;

  // Requester signals gathered into indexable form so both sides share logic.
  logic [1:0]   w_req_valid;
  logic [1:0]   w_req_ready;
  logic [1:0]   w_rsp_ready;
  logic [1:0]   w_rsp_valid;
  logic [w-1:0] w_req_op [2];
  logic [w-1:0] w_req_a  [2];
  logic [w-1:0] w_req_b  [2];

  logic         w_grant;
  logic         w_accept;
  logic         w_done;

  assign w_req_valid = {req1_valid, req0_valid};
  assign w_rsp_ready = {rsp1_ready, rsp0_ready};
  assign w_req_op[0] = req0_opcode;
  assign w_req_op[1] = req1_opcode;
  assign w_req_a[0]  = req0_a;
  assign w_req_a[1]  = req1_a;
  assign w_req_b[0]  = req0_b;
  assign w_req_b[1]  = req1_b;

  // Grant: the priority holder wins a tie, otherwise whoever is asking.
  always_comb begin
    w_grant = 1'b0;
    if (&w_req_valid) begin
      w_grant = r_prio;
    end else if (w_req_valid[1]) begin
      w_grant = 1'b1;
    end
  end

  // Per-requester ready and response-valid decode.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign w_req_ready[gi] = !rst && (r_state == IDLE) &&
                               (w_grant == 1'(gi)) && w_req_valid[gi];
      assign w_rsp_valid[gi] = (r_state == RESP) && (r_owner == 1'(gi));
    end
  endgenerate

  assign w_accept = |w_req_ready;
  // Response completes only when the owning requester takes it.
  assign w_done   = (r_state == RESP) && w_rsp_ready[r_owner];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and status decode: IDLE -> EXEC -> RESP -> IDLE.
  always_comb begin
    w_state_next = r_state;
    busy         = (r_state != IDLE);
    case (r_state)
      IDLE:    if (w_accept) w_state_next = EXEC;
      EXEC:    w_state_next = RESP;
      RESP:    if (w_done) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Operand capture, result capture and round-robin priority update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_owner <= 1'b0;
      r_prio  <= 1'b0;
    end else begin
      if ((r_state == IDLE) && w_accept) begin
        r_op    <= w_req_op[w_grant];
        r_a     <= w_req_a[w_grant];
        r_b     <= w_req_b[w_grant];
        r_owner <= w_grant;
      end
      if (r_state == EXEC) begin
        r_res <= alu_y;
      end
      // Priority moves only when a response is handed over, not on accept.
      if (w_done) begin
        r_prio <= ~r_owner;
      end
    end
  end

  assign req0_ready = w_req_ready[0];
  assign req1_ready = w_req_ready[1];
  assign rsp0_valid = w_rsp_valid[0];
  assign rsp1_valid = w_rsp_valid[1];
  // Both response buses carry the captured result; valid says whose it is.
  assign rsp0_y     = r_res;
  assign rsp1_y     = r_res;
  // The ALU only ever sees registered operands.
  assign alu_opcode = r_op;
  assign alu_a      = r_a;
  assign alu_b      = r_b;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: behavioural shift ALU attached, scoreboard of
// expected responses pushed on acceptance and popped on response handshake.
module tb_alu_arbiter;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready;
  logic [W-1:0] req0_opcode, req0_a, req0_b;
  logic         req1_valid, req1_ready;
  logic [W-1:0] req1_opcode, req1_a, req1_b;
  logic         rsp0_valid, rsp0_ready;
  logic [W-1:0] rsp0_y;
  logic         rsp1_valid, rsp1_ready;
  logic [W-1:0] rsp1_y;
  logic [W-1:0] alu_opcode, alu_a, alu_b, alu_y;
  logic         busy;

  always #5 clk = ~clk;

  alu_arbiter #(.w(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_y(rsp0_y),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_y(rsp1_y),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
    .busy(busy)
  );

  // Shift ALU: 0 = LLS, 1 = LRS, 2 = ARS, anything else behaves as LLS.
  function automatic logic [W-1:0] alu_model(input logic [W-1:0] op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [W-1:0] r;
    case (op)
      3'd1:    r = a >> b;
      3'd2:    r = W'($signed(a) >>> b);
      default: r = a << b;
    endcase
    return r;
  endfunction

  assign alu_y = alu_model(alu_opcode, alu_a, alu_b);

  typedef struct packed {
    logic         owner;
    logic [W-1:0] y;
  } sb_t;

  typedef struct {
    bit           r;
    logic [W-1:0] op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
  } vec_t;

  sb_t          sb[$];
  logic [W-1:0] exp0, exp1;
  int           checks = 0;
  int           errors = 0;
  int           cyc    = 0;
  bit           acc0, acc1;
  int           acc_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic take_rsp(input logic owner, input logic [W-1:0] y);
    sb_t e;
    if (sb.size() == 0) begin
      check("rsp_unexpected", 32'(owner), 32'hFFFF);
    end else begin
      e = sb.pop_front();
      check("rsp_owner", 32'(owner), 32'(e.owner));
      check("rsp_y", 32'(y), 32'(e.y));
      $display("rsp owner=%0d y=%b expected_owner=%0d expected_y=%b", owner, y, e.owner, e.y);
    end
  endtask

  // One clock: monitor at the falling edge, then advance past the rising edge.
  task automatic tick();
    @(negedge clk);
    acc0 = 1'b0;
    acc1 = 1'b0;
    check("one_ready", 32'(req0_ready && req1_ready), 0);
    check("rsp_exclusive", 32'(rsp0_valid && rsp1_valid), 0);
    if (req0_valid && req0_ready) begin
      acc0 = 1'b1;
      acc_cyc = cyc;
      sb.push_back({1'b0, exp0});
    end
    if (req1_valid && req1_ready) begin
      acc1 = 1'b1;
      acc_cyc = cyc;
      sb.push_back({1'b1, exp1});
    end
    if (rsp0_valid && rsp0_ready) take_rsp(1'b0, rsp0_y);
    if (rsp1_valid && rsp1_ready) take_rsp(1'b1, rsp1_y);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 20) begin
      tick();
      n++;
    end
    if (sb.size() > 0) check("drain_timeout", 32'(sb.size()), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic drive(input bit r, input logic [W-1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] y);
    if (r) begin
      req1_valid = 1'b1; req1_opcode = op; req1_a = a; req1_b = b; exp1 = y;
    end else begin
      req0_valid = 1'b1; req0_opcode = op; req0_a = a; req0_b = b; exp0 = y;
    end
  endtask

  // Single operation with response ready held high; checks EXEC contents and latency.
  task automatic run_op(input vec_t v);
    int n = 0;
    drive(v.r, v.op, v.a, v.b, v.y);
    do begin
      tick();
      n++;
    end while (!(v.r ? acc1 : acc0) && n < 20);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (!(v.r ? acc1 : acc0)) begin
      check("accept_timeout", 0, 1);
      return;
    end
    @(negedge clk);
    check("exec_alu_opcode", 32'(alu_opcode), 32'(v.op));
    check("exec_alu_a", 32'(alu_a), 32'(v.a));
    check("exec_alu_b", 32'(alu_b), 32'(v.b));
    check("exec_busy", 32'(busy), 1);
    check("exec_no_rsp", 32'(rsp0_valid || rsp1_valid), 0);
    @(posedge clk);
    #1;
    cyc++;
    tick();
    check("latency", 32'(sb.size()), 0);
    check("idle_busy", 32'(busy), 0);
  endtask

  vec_t vecs[10];

  initial begin
    int   order[$];
    int   times[$];
    int   n;
    logic [W-1:0] held_y;

    vecs[0] = '{1'b0, 3'd0, 3'b011, 3'd1, 3'b110};
    vecs[1] = '{1'b1, 3'd1, 3'b110, 3'd1, 3'b011};
    vecs[2] = '{1'b0, 3'd2, 3'b100, 3'd1, 3'b110};
    vecs[3] = '{1'b1, 3'd2, 3'b011, 3'd1, 3'b001};
    vecs[4] = '{1'b0, 3'd0, 3'b111, 3'd0, 3'b111};
    vecs[5] = '{1'b1, 3'd1, 3'b101, 3'd2, 3'b001};
    vecs[6] = '{1'b0, 3'd7, 3'b001, 3'd2, 3'b100};
    vecs[7] = '{1'b1, 3'd2, 3'b100, 3'd2, 3'b111};
    vecs[8] = '{1'b0, 3'd0, 3'b011, 3'd3, 3'b000};
    vecs[9] = '{1'b1, 3'd3, 3'b010, 3'd1, 3'b100};

    rst = 1'b1;
    req0_valid = 1'b1; req0_opcode = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b1; req1_opcode = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    exp0 = '0; exp1 = '0;

    // Reset state, with both requesters asking.
    tick();
    tick();
    check("rst_req0_ready", 32'(req0_ready), 0);
    check("rst_req1_ready", 32'(req1_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 0);
    check("rst_alu", 32'({alu_opcode, alu_a, alu_b}), 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;
    sb.delete();

    // Tie and alternation straight out of reset.
    drive(1'b0, 3'd1, 3'b110, 3'd1, 3'b011);
    drive(1'b1, 3'd2, 3'b100, 3'd1, 3'b110);
    n = 0;
    while (order.size() < 3 && n < 30) begin
      tick();
      n++;
      if (acc0) begin order.push_back(0); times.push_back(acc_cyc); end
      if (acc1) begin order.push_back(1); times.push_back(acc_cyc); end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("tie_count", 32'(order.size()), 3);
    if (order.size() == 3) begin
      check("tie_first", 32'(order[0]), 0);
      check("tie_second", 32'(order[1]), 1);
      check("tie_third", 32'(order[2]), 0);
      check("tie_gap", 32'(times[2] - times[0]), 6);
    end
    drain();

    // Table of single operations.
    for (int i = 0; i < 10; i++) run_op(vecs[i]);

    // Backpressure on requester 1 while requester 0 waits.
    rsp1_ready = 1'b0;
    drive(1'b1, 3'd2, 3'b011, 3'd1, 3'b001);
    n = 0;
    do begin tick(); n++; end while (!acc1 && n < 20);
    req1_valid = 1'b0;
    drive(1'b0, 3'd0, 3'b001, 3'd1, 3'b010);
    n = 0;
    while (!rsp1_valid && n < 10) begin tick(); n++; end
    check("bp_rsp1_valid_rise", 32'(rsp1_valid), 1);
    held_y = rsp1_y;
    check("bp_rsp1_y", 32'(held_y), 32'(3'b001));
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", 32'(rsp1_valid), 1);
      check("bp_hold_y", 32'(rsp1_y), 32'(held_y));
      check("bp_req0_blocked", 32'(req0_ready), 0);
      tick();
    end
    rsp1_ready = 1'b1;
    check("bp_req0_blocked_last", 32'(req0_ready), 0);
    tick();
    check("bp_req0_ready_after", 32'(req0_ready), 1);
    tick();
    check("bp_req0_accepted", 32'(acc0), 1);
    req0_valid = 1'b0;
    drain();

    // Lone requester 1 served back-to-back.
    order.delete();
    times.delete();
    drive(1'b1, 3'd0, 3'b001, 3'd1, 3'b010);
    n = 0;
    while (times.size() < 4 && n < 40) begin
      tick();
      n++;
      if (acc1) times.push_back(acc_cyc);
    end
    req1_valid = 1'b0;
    check("lone_count", 32'(times.size()), 4);
    for (int i = 1; i < times.size(); i++)
      check("lone_gap", 32'(times[i] - times[i-1]), 3);
    drain();

    // Reset while in RESP; priority left at 1 beforehand by a req0 completion.
    run_op('{1'b0, 3'd0, 3'b001, 3'd1, 3'b010});
    rsp0_ready = 1'b0;
    drive(1'b0, 3'd1, 3'b100, 3'd2, 3'b001);
    n = 0;
    do begin tick(); n++; end while (!acc0 && n < 20);
    req0_valid = 1'b0;
    n = 0;
    while (!rsp0_valid && n < 10) begin tick(); n++; end
    check("mid_in_resp", 32'(rsp0_valid), 1);
    do_reset();
    check("mid_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 0);
    check("mid_busy", 32'(busy), 0);
    check("mid_alu", 32'({alu_opcode, alu_a, alu_b}), 0);
    rsp0_ready = 1'b1;
    drive(1'b0, 3'd0, 3'b001, 3'd1, 3'b010);
    drive(1'b1, 3'd1, 3'b100, 3'd1, 3'b010);
    tick();
    check("mid_tie_req0", 32'({acc1, acc0}), 32'(2'b01));
    req0_valid = 1'b0;
    n = 0;
    while (!acc1 && n < 20) begin tick(); n++; end
    check("mid_tie_req1_later", 32'(acc1), 1);
    req1_valid = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
